sipo_deser: RTL
===============

# sipo_deser

Serial-in/parallel-out deserializer that consumes the single-bit stream produced by the master-slave D flip-flop stage and assembles it into WIDTH-bit words. It sits directly downstream of that flip-flop: the flip-flop's Q feeds `din`, and a strobe marks each valid bit. Completed words are held in a one-entry output buffer and handed to the consumer with a valid/ready handshake. Words that complete while the buffer is still occupied are dropped, and a sticky overrun flag is raised.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock, the only clock.
- `rst`  input  1  asynchronous reset, active-high.
- `clr`  input  1  synchronous clear: resets the assembly state and the overrun flag.
- `din`  input  1  serial data bit (the flip-flop's Q).
- `din_valid`  input  1  `din` is sampled on this edge.
- `out_ready`  input  1  consumer accepts `dout` this cycle.
- `dout`  output  WIDTH  assembled word.
- `dout_valid`  output  1  `dout` holds an unconsumed word.
- `bit_cnt`  output  clog2(WIDTH)  number of bits collected for the word in progress.
- `overrun`  output  1  sticky: at least one word was dropped.

## Operation
- Reset (async, `rst`=1): shift register=0, `bit_cnt`=0, `dout`=0, `dout_valid`=0, `overrun`=0. All outputs hold these values while `rst` is high.
- Shift, on a rising edge with `din_valid`=1:
  - LSB-first by default: `sh <= {din, sh[WIDTH-1:1]}`.
  - `bit_cnt` increments.
- Word complete, when `din_valid`=1 and `bit_cnt`==WIDTH-1:
  - The completed word is the current shift contents combined with `din`.
  - `bit_cnt` wraps to 0.
- Buffer free means `dout_valid`=0, or `dout_valid`=1 with `out_ready`=1 on the same edge.
- Complete word with buffer free: `dout` <= completed word and `dout_valid` <= 1. Back-to-back loads keep `dout_valid` continuously high.
- Complete word with buffer full (`dout_valid`=1, `out_ready`=0):
  - The word is dropped.
  - `dout` is unchanged.
  - `overrun` <= 1.
- Handshake: a transfer occurs on an edge where `dout_valid`=1 and `out_ready`=1. With no simultaneous load, `dout_valid` <= 0; `dout` keeps its last value.
- `dout` is stable while `dout_valid`=1 and `out_ready`=0.
- `clr`=1:
  - Shift register, `bit_cnt` and `overrun` clear to 0; `din` on that edge is ignored.
  - The output buffer is also emptied (`dout_valid` <= 0); `dout` keeps its value.
  - `clr` has priority over shift, load and handshake.
- `din_valid`=0: shift register and `bit_cnt` hold.

## Timing
- The sampling edge is the rising edge of `clk`. `din` comes from a flip-flop clocked on the same edge, so it is stable across the edge.
- Latency: if the final bit is sampled on edge N, then `dout_valid`=1 and `dout` are valid right after edge N (zero extra cycles).
- Maximum sustained throughput is one bit per cycle, which gives one word every WIDTH cycles. The consumer may take up to WIDTH-1 cycles after `dout_valid` rises without causing an overrun.
- Asserting `rst` mid-word discards the partial word immediately, without waiting for a clock edge.
- `overrun` is cleared only by `rst` or `clr`.

## Configuration
- Macro `SIPO_MSB_FIRST_EN`.
- Defined: bits are MSB-first. Shift is `sh <= {sh[WIDTH-2:0], din}`, so the first received bit lands in `dout[WIDTH-1]`.
- Undefined (default): LSB-first. The first received bit lands in `dout[0]`.
- The macro changes no ports or timing.

## Structure
- Shared package/header `sipo_defs` holds:
  - the `WIDTH` default;
  - the `bit_cnt` width function (clog2);
  - the reset value constant for `dout`.
- One sub-module, `sipo_out_buf`, implements the one-entry output buffer:
  - inputs: load, word, `out_ready`, `clr`;
  - outputs: `dout`, `dout_valid`, full-drop indication.
- Top level `sipo_deser` contains the shift register, bit counter, overrun flag and the macro-selected shift direction.

## Test plan
- Reset: hold `rst`=1, toggle `din`/`din_valid` -> all outputs 0. Release `rst`, send 8 bits of 0xA5 (LSB-first) with `out_ready`=1 -> `dout`=0xA5 and `dout_valid`=1 right after the 8th edge, then 0 on the next edge.
- Back-to-back: stream 0x3C then 0xC3 continuously with `out_ready` held 1 -> `dout` changes 0x3C -> 0xC3; `dout_valid` pulses once per 8 cycles; `overrun`=0.
- Backpressure:
  - `out_ready`=0 while 0x11 and then 0x22 complete -> `dout` stays 0x11; `overrun` becomes 1 on the edge where 0x22 completes.
  - Raise `out_ready` -> `dout_valid` falls; `overrun` stays 1.
- Simultaneous: `dout_valid`=1 holding 0x55, `out_ready`=1 on the same edge that 0x66 completes -> `dout`=0x66, `dout_valid` stays 1, no overrun.
- Clear/reset mid-word:
  - After 3 bits, pulse `clr` -> `bit_cnt`=0. The next 8 bits form a clean word.
  - Repeat with an async `rst` pulse between clock edges -> outputs go to 0 immediately.
- `SIPO_MSB_FIRST_EN` build: send bits 1,0,0,0,0,0,0,0 -> `dout`=0x80 (the LSB-first build yields 0x01).

Source files
------------

// File: rtl/sipo_defs.sv
// Shared definitions for the serial-in/parallel-out deserializer.
package sipo_defs;

    localparam int WIDTH_DEF = 8;

    // Reset value of the parallel output; sliced to the word width where used.
    localparam logic [31:0] DOUT_RST = 32'h0000_0000;

    // Bits needed for a counter holding 0..w-1 (w is at least 2).
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry output buffer with valid/ready handoff; flags loads that arrive while it is full.
module sipo_out_buf
    import sipo_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             drop
);

    logic [WIDTH-1:0] dout_reg;
    logic             valid_reg;
    logic             buf_free;

    // A word being taken on this edge frees the slot for a simultaneous load.
    assign buf_free = !valid_reg || out_ready;
    assign drop     = load && !clr && !buf_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_reg  <= DOUT_RST[WIDTH-1:0];
            valid_reg <= 1'b0;
        end else if (clr) begin
            valid_reg <= 1'b0;
        end else if (load && buf_free) begin
            dout_reg  <= word;
            valid_reg <= 1'b1;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = valid_reg;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with one-entry output buffer and sticky overrun flag.
// Define SIPO_MSB_FIRST_EN for MSB-first bit order; LSB-first otherwise.
module sipo_deser
    import sipo_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     din,
    input  logic                     din_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic [cnt_w(WIDTH)-1:0]  bit_cnt,
    output logic                     overrun
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_reg, sh_next, shifted;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             overrun_reg, overrun_next;
    logic             complete;
    logic             drop;

`ifdef SIPO_MSB_FIRST_EN
    assign shifted = {sh_reg[WIDTH-2:0], din};
`else
    assign shifted = {din, sh_reg[WIDTH-1:1]};
`endif

    always_comb begin
        sh_next      = sh_reg;
        cnt_next     = cnt_reg;
        complete     = 1'b0;
        overrun_next = overrun_reg || drop;
        if (clr) begin
            sh_next      = '0;
            cnt_next     = '0;
            overrun_next = 1'b0;
        end else if (din_valid) begin
            sh_next  = shifted;
            complete = (cnt_reg == LAST);
            cnt_next = complete ? '0 : cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_reg      <= '0;
            cnt_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            sh_reg      <= sh_next;
            cnt_reg     <= cnt_next;
            overrun_reg <= overrun_next;
        end
    end

    // The completed word is the shift contents with the final bit already merged in.
    sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .load       (complete),
        .word       (sh_next),
        .out_ready  (out_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .drop       (drop)
    );

    assign bit_cnt = cnt_reg;
    assign overrun = overrun_reg;

endmodule
